// File: rtl/mips_defs.sv
// Shared MIPS decode constants, Tuse/Tnew codes and the per-instruction
// classification record used by the hazard/stall controller.
package mips_defs;

   localparam int unsigned REG_W = 5;
   localparam int unsigned T_W   = 2;

   typedef logic [T_W-1:0]   tcode_t;
   typedef logic [REG_W-1:0] reg_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam tcode_t T_0 = 2'd0;
   localparam tcode_t T_1 = 2'd1;
   localparam tcode_t T_2 = 2'd2;

   localparam reg_t REG_ZERO = 5'd0;
   localparam reg_t REG_RA   = 5'd31;

   typedef struct packed {
      logic   rs_used;
      logic   rt_used;
      tcode_t tuse_rs;
      tcode_t tuse_rt;
      reg_t   dest;
      tcode_t tnew_e;
      logic   is_md;
      logic   is_mult;
      logic   is_div;
   } instr_info_t;

   // A source conflicts with a producer only if the value is not ready in time.
   function automatic logic src_hazard(input reg_t src, input tcode_t tuse,
                                       input reg_t dst, input tcode_t tnew);
      return (src != REG_ZERO) && (src == dst) && (tuse < tnew);
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle: instructions in D/E/M and the stall/flush controls.
interface hazard_stall_ctrl_if;
   logic [31:0] D_IR;
   logic [31:0] DE_IR;
   logic [31:0] EM_IR;
   logic        PcEnable;
   logic        FdEnable;
   logic        DeFlush;
   logic        MdStart;
   logic        MdBusy;

   modport master (output D_IR, DE_IR, EM_IR,
                   input  PcEnable, FdEnable, DeFlush, MdStart, MdBusy);
   modport slave  (input  D_IR, DE_IR, EM_IR,
                   output PcEnable, FdEnable, DeFlush, MdStart, MdBusy);
endinterface

// File: rtl/instr_class.sv
// Decodes one instruction word into its register usage, timing and MD class.
module instr_class
   import mips_defs::*;
(
   input  logic [31:0] ir,
   output instr_info_t info
);

   logic [5:0] op;
   logic [5:0] fn;
   reg_t       rt;
   reg_t       rd;
   logic       unused_shamt;

   assign op = ir[31:26];
   assign fn = ir[5:0];
   assign rt = ir[20:16];
   assign rd = ir[15:11];
   assign unused_shamt = ^ir[10:6];

   always_comb begin
      info = '0;
      unique case (op)
         OP_RTYPE: begin
            unique case (fn)
               FN_ADDU, FN_SUBU: begin
                  info.rs_used = 1'b1;
                  info.rt_used = 1'b1;
                  info.tuse_rs = T_1;
                  info.tuse_rt = T_1;
                  info.dest    = rd;
                  info.tnew_e  = T_1;
               end
               FN_JR: begin
                  info.rs_used = 1'b1;
                  info.tuse_rs = T_0;
               end
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                  info.rs_used = 1'b1;
                  info.rt_used = 1'b1;
                  info.tuse_rs = T_1;
                  info.tuse_rt = T_1;
                  info.is_md   = 1'b1;
                  info.is_mult = (fn == FN_MULT) || (fn == FN_MULTU);
                  info.is_div  = (fn == FN_DIV)  || (fn == FN_DIVU);
               end
               FN_MFHI, FN_MFLO: begin
                  info.dest   = rd;
                  info.tnew_e = T_1;
                  info.is_md  = 1'b1;
               end
               FN_MTHI, FN_MTLO: begin
                  info.rs_used = 1'b1;
                  info.tuse_rs = T_1;
                  info.is_md   = 1'b1;
               end
               default: ;
            endcase
         end
         OP_ORI, OP_LW: begin
            info.rs_used = 1'b1;
            info.tuse_rs = T_1;
            info.dest    = rt;
            info.tnew_e  = (op == OP_LW) ? T_2 : T_1;
         end
         OP_LUI: begin
            info.dest   = rt;
            info.tnew_e = T_1;
         end
         OP_SW: begin
            info.rs_used = 1'b1;
            info.rt_used = 1'b1;
            info.tuse_rs = T_1;
            info.tuse_rt = T_2;
         end
         OP_BEQ: begin
            info.rs_used = 1'b1;
            info.rt_used = 1'b1;
            info.tuse_rs = T_0;
            info.tuse_rt = T_0;
         end
         OP_JAL: begin
            info.dest   = REG_RA;
            info.tnew_e = T_1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush control for PC, FD and DE: unresolvable data hazards plus the
// mult/div busy window that holds HI/LO instructions in D.
module hazard_stall_ctrl
   import mips_defs::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input  logic                Clock,
   input  logic                Reset,
   hazard_stall_ctrl_if.slave  bus
);

   instr_info_t d_info;
   instr_info_t e_info;
   instr_info_t m_info;
   logic [CNT_W-1:0] cnt;
   tcode_t tnew_m;
   reg_t   d_rs;
   reg_t   d_rt;
   logic   rs_stall;
   logic   rt_stall;
   logic   md_start;
   logic   md_busy;
   logic   stall;
   logic   unused_info;

   instr_class u_class_d (.ir(bus.D_IR),  .info(d_info));
   instr_class u_class_e (.ir(bus.DE_IR), .info(e_info));
   instr_class u_class_m (.ir(bus.EM_IR), .info(m_info));

   assign unused_info = ^{d_info.dest, d_info.tnew_e, d_info.is_mult, d_info.is_div,
                          e_info.rs_used, e_info.rt_used, e_info.tuse_rs,
                          e_info.tuse_rt, e_info.is_md,
                          m_info.rs_used, m_info.rt_used, m_info.tuse_rs,
                          m_info.tuse_rt, m_info.is_md, m_info.is_mult, m_info.is_div};

   // One stage later, the producer's remaining latency drops by one (floored at 0).
   assign tnew_m = (m_info.tnew_e != T_0) ? T_W'(m_info.tnew_e - T_1) : T_0;
   assign d_rs   = bus.D_IR[25:21];
   assign d_rt   = bus.D_IR[20:16];

   assign rs_stall = d_info.rs_used &&
                     (src_hazard(d_rs, d_info.tuse_rs, e_info.dest, e_info.tnew_e) ||
                      src_hazard(d_rs, d_info.tuse_rs, m_info.dest, tnew_m));
   assign rt_stall = d_info.rt_used &&
                     (src_hazard(d_rt, d_info.tuse_rt, e_info.dest, e_info.tnew_e) ||
                      src_hazard(d_rt, d_info.tuse_rt, m_info.dest, tnew_m));

   assign md_start = e_info.is_mult || e_info.is_div;
   assign md_busy  = md_start || (cnt != '0);
   assign stall    = rs_stall || rt_stall || (d_info.is_md && md_busy);

   // Busy countdown; a new start reloads even if a previous window is running.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt <= '0;
      end else if (md_start) begin
         cnt <= e_info.is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign bus.PcEnable = !stall;
   assign bus.FdEnable = !stall;
   assign bus.DeFlush  = stall;
   assign bus.MdStart  = md_start;
   assign bus.MdBusy   = md_busy;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; expected control words are queued by
// the driver and checked by an independent monitor on the falling edge.
module tb_hazard_stall_ctrl;

   // Expected word order: {PcEnable, FdEnable, DeFlush, MdStart, MdBusy}
   localparam logic [4:0] RUN     = 5'b11000;
   localparam logic [4:0] STL     = 5'b00100;
   localparam logic [4:0] MD_STL0 = 5'b00111;
   localparam logic [4:0] MD_STL  = 5'b00101;
   localparam logic [4:0] MD_RUN0 = 5'b11011;
   localparam logic [4:0] MD_RUN  = 5'b11001;

   localparam logic [31:0] NOP      = 32'h00000000;
   localparam logic [31:0] LW1      = 32'h8C010000;
   localparam logic [31:0] LW0      = 32'h8C000000;
   localparam logic [31:0] ADDU_211 = 32'h00211021;
   localparam logic [31:0] ADDU_200 = 32'h00001021;
   localparam logic [31:0] ADDU_1   = 32'h00000821;
   localparam logic [31:0] BEQ_10   = 32'h10200000;
   localparam logic [31:0] SW_12    = 32'hAC410000;
   localparam logic [31:0] JR_31    = 32'h03E00008;
   localparam logic [31:0] JAL      = 32'h0C000000;
   localparam logic [31:0] MULT     = 32'h00220018;
   localparam logic [31:0] MULTU    = 32'h00220019;
   localparam logic [31:0] DIV      = 32'h0022001A;
   localparam logic [31:0] MFLO_3   = 32'h00001812;
   localparam logic [31:0] MTHI_1   = 32'h00200011;

   logic Clock;
   logic Reset;
   hazard_stall_ctrl_if bus ();

   hazard_stall_ctrl dut (.Clock(Clock), .Reset(Reset), .bus(bus));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic [4:0] exp_q[$];
   string      name_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic apply(input logic rst, input logic [31:0] d, input logic [31:0] de,
                        input logic [31:0] em, input logic [4:0] exp, input string nm);
      @(posedge Clock);
      #1;
      Reset     = rst;
      bus.D_IR  = d;
      bus.DE_IR = de;
      bus.EM_IR = em;
      exp_q.push_back(exp);
      name_q.push_back(nm);
   endtask

   // Monitor: outputs are combinational and valid every cycle.
   always @(negedge Clock) begin
      if (exp_q.size() > 0) begin
         logic [4:0] act;
         logic [4:0] exp;
         string      nm;
         act = {bus.PcEnable, bus.FdEnable, bus.DeFlush, bus.MdStart, bus.MdBusy};
         exp = exp_q.pop_front();
         nm  = name_q.pop_front();
         n_cmp++;
         if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (Pc,Fd,Flush,Start,Busy)", nm, act, exp);
         end
      end
   end

   initial begin
      Reset     = 1'b1;
      bus.D_IR  = NOP;
      bus.DE_IR = NOP;
      bus.EM_IR = NOP;
      @(posedge Clock);

      apply(1'b1, NOP, NOP, NOP, RUN, "reset_idle");
      apply(1'b0, NOP, NOP, NOP, RUN, "post_reset_idle");

      apply(1'b0, ADDU_211, LW1, NOP, STL, "loaduse_e");
      apply(1'b0, ADDU_211, NOP, LW1, RUN, "loaduse_m_released");

      apply(1'b0, BEQ_10, ADDU_1, NOP, STL, "beq_addu_e");
      apply(1'b0, BEQ_10, NOP, LW1, STL, "beq_lw_m");
      apply(1'b0, BEQ_10, NOP, ADDU_1, RUN, "beq_addu_m");
      apply(1'b0, SW_12, NOP, LW1, RUN, "sw_rt_lw_m");
      apply(1'b0, SW_12, LW1, NOP, RUN, "sw_rt_lw_e");
      apply(1'b0, JR_31, JAL, NOP, STL, "jr_jal_e");
      apply(1'b0, JR_31, NOP, JAL, RUN, "jr_jal_m");

      apply(1'b0, MFLO_3, MULT, NOP, MD_STL0, "mult_start");
      for (int i = 0; i < 5; i++) apply(1'b0, MFLO_3, NOP, NOP, MD_STL, "mult_busy");
      apply(1'b0, MFLO_3, NOP, NOP, RUN, "mflo_release");

      apply(1'b0, NOP, DIV, NOP, MD_RUN0, "div_start");
      for (int i = 0; i < 10; i++) apply(1'b0, NOP, NOP, NOP, MD_RUN, "div_busy");
      apply(1'b0, NOP, NOP, NOP, RUN, "div_done");

      apply(1'b0, NOP, DIV, NOP, MD_RUN0, "div2_start");
      apply(1'b0, NOP, NOP, NOP, MD_RUN, "div2_busy2");
      apply(1'b1, NOP, NOP, NOP, MD_RUN, "div2_reset_cycle");
      apply(1'b0, NOP, NOP, NOP, RUN, "div2_after_reset");

      apply(1'b1, NOP, DIV, NOP, MD_RUN0, "reset_with_start");
      apply(1'b0, NOP, NOP, NOP, RUN, "reset_beats_start");

      apply(1'b0, NOP, MULTU, NOP, MD_RUN0, "multu_start");
      apply(1'b1, MTHI_1, NOP, LW1, MD_STL, "data_and_md_stall");
      apply(1'b0, NOP, NOP, NOP, RUN, "combo_cleared");

      apply(1'b0, ADDU_200, LW0, NOP, RUN, "zero_reg_excluded");

      repeat (3) @(posedge Clock);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
